// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MIPS MEM-stage sequencer. Issues an EX/MEM access to a variable-latency
//   data memory over req/ack, stalls the pipeline while it is outstanding and resolves branches.
// Latency: minimum 2 stall cycles per aligned access (issue + one REQ cycle); load data visible in DONE.
// Backpressure: stall_o holds PC..EX/MEM while an access is issuing/outstanding; aborts after TIMEOUT REQ cycles.
// Ports: clk/rst (async active-low); EX/MEM controls mem_read_i/mem_write_i/branch_i/zero_i,
//   addr_i/wdata_i; memory side mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o, mem_ack_i/mem_rdata_i;
//   pipeline side rdata_o/rdata_valid_o, stall_o, pc_src_o, flush_o; status align_err_o,
//   timeout_err_o (sticky), stall_cnt_o (saturating).
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic             branch_i,
  input  logic             zero_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_ack_i,
  input  logic [31:0]      mem_rdata_i,
  output logic [31:0]      rdata_o,
  output logic             rdata_valid_o,
  output logic             stall_o,
  output logic             pc_src_o,
  output logic             flush_o,
  output logic             align_err_o,
  output logic             timeout_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       tmo_cnt_q, tmo_cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvld_q, rvld_d;
  logic             align_q, align_d;
  logic             tmo_err_q, tmo_err_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic             stall;
  logic             acc;
  logic             aligned;

  assign acc     = mem_read_i | mem_write_i;
  assign aligned = (addr_i[1:0] == 2'b00);

  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rvld_d    = 1'b0;
    align_d   = 1'b0;
    tmo_err_d = tmo_err_q;
    stall     = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc) begin
          if (aligned) begin
            stall     = 1'b1;
            req_d     = 1'b1;
            we_d      = mem_write_i;  // read+write together counts as a write
            addr_d    = addr_i;
            wdata_d   = wdata_i;
            tmo_cnt_d = '0;
            state_d   = REQ;
          end else begin
            // Misaligned: never touch memory, just report and let the instruction leave.
            align_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      REQ: begin
        stall     = 1'b1;
        tmo_cnt_d = tmo_cnt_q + 8'd1;
        if (mem_ack_i) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            rdata_d = mem_rdata_i;
            rvld_d  = 1'b1;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          req_d     = 1'b0;
          we_d      = 1'b0;
          tmo_err_d = 1'b1;
          state_d   = DONE;
          if (!we_q) begin
            rdata_d = '0;  // aborted load returns zero so MEM/WB still sees a defined value
            rvld_d  = 1'b1;
          end
        end
      end
      // The instruction still presented here is the one that just completed; never re-issue.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scnt_d = scnt_q;
    if (stall && (scnt_q != {CNT_W{1'b1}})) scnt_d = scnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tmo_cnt_q <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rvld_q    <= 1'b0;
      align_q   <= 1'b0;
      tmo_err_q <= 1'b0;
      scnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rvld_q    <= rvld_d;
      align_q   <= align_d;
      tmo_err_q <= tmo_err_d;
      scnt_q    <= scnt_d;
    end
  end

  assign mem_req_o     = req_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvld_q;
  assign align_err_o   = align_q;
  assign timeout_err_o = tmo_err_q;
  assign stall_cnt_o   = scnt_q;
  assign stall_o       = stall;
  assign pc_src_o      = branch_i & zero_i;
  // A taken branch must not flush stages that are being held; it fires once the stall releases.
  assign flush_o       = pc_src_o & ~stall;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed + randomized bench for mem_stage_ctrl.
// Latency: checks observed one time unit after each falling edge.
// Backpressure: memory ack delay chosen per access; TIMEOUT=4 so long delays abort.
module tb_mem_stage_ctrl;

  localparam int TMO   = 4;
  localparam int CW    = 6;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mem_read_i = 1'b0, mem_write_i = 1'b0, branch_i = 1'b0, zero_i = 1'b0;
  logic [31:0]   addr_i = '0, wdata_i = '0;
  logic          mem_req_o, mem_we_o;
  logic [31:0]   mem_addr_o, mem_wdata_o;
  logic          mem_ack_i = 1'b0;
  logic [31:0]   mem_rdata_i = '0;
  logic [31:0]   rdata_o;
  logic          rdata_valid_o, stall_o, pc_src_o, flush_o, align_err_o, timeout_err_o;
  logic [CW-1:0] stall_cnt_o;

  int total = 0;
  int bad   = 0;
  // Reference state: accumulated stall cycles (saturating) and sticky timeout.
  int m_cnt = 0;
  bit m_tmo = 1'b0;

  mem_stage_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .branch_i(branch_i), .zero_i(zero_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .stall_o(stall_o), .pc_src_o(pc_src_o), .flush_o(flush_o),
    .align_err_o(align_err_o), .timeout_err_o(timeout_err_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One EX/MEM instruction held until it leaves the MEM stage. dly = number of REQ cycles
  // before the ack (0 = ack in the first REQ cycle); dly >= TMO means the memory never answers.
  task automatic do_acc(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdv, input int dly, input bit br, input bit z);
    bit   has_acc = rd | wr;
    bit   is_wr   = wr;
    bit   al      = (a[1:0] == 2'b00);
    bit   issue   = has_acc & al;
    int   req_exp = issue ? ((dly + 1 < TMO) ? dly + 1 : TMO) : 0;
    bit   to_exp  = issue & (dly + 1 > TMO);
    int   st_exp  = issue ? 1 + req_exp : 0;
    int   reqc    = 0;
    int   stalls  = 0;
    bit   done    = 1'b0;
    @(negedge clk);
    mem_ack_i   = 1'b0;
    mem_read_i  = rd;
    mem_write_i = wr;
    addr_i      = a;
    wdata_i     = wd;
    branch_i    = br;
    zero_i      = z;
    #1;
    chk("rvld_before_issue", rdata_valid_o, 0);
    chk("align_before_issue", align_err_o, 0);
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (stall_o) stalls++;
      chk("pc_src", pc_src_o, br & z);
      if (cyc > 0 && !mem_req_o) begin
        done = 1'b1;
        chk("done_stall", stall_o, 0);
        chk("done_flush", flush_o, br & z);
        chk("done_we", mem_we_o, 0);
        chk("done_align", align_err_o, has_acc & ~al);
        chk("done_rvld", rdata_valid_o, issue & ~is_wr);
        if (issue & ~is_wr) chk("done_rdata", rdata_o, to_exp ? 32'h0 : rdv);
        break;
      end
      chk("stall", stall_o, (cyc == 0) ? issue : 1'b1);
      chk("flush_held", flush_o, (cyc == 0 && !issue) ? (br & z) : 1'b0);
      if (mem_req_o) begin
        chk("req_addr", mem_addr_o, a);
        chk("req_we", mem_we_o, is_wr);
        chk("req_wdata", mem_wdata_o, wd);
        if (reqc == dly) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = rdv;
        end
        reqc++;
      end
      @(negedge clk);
      mem_ack_i   = 1'b0;
      mem_rdata_i = $urandom;
      #1;
    end
    if (!done) chk("wait_done_budget", 0, 1);
    m_tmo = m_tmo | to_exp;
    m_cnt = (m_cnt + st_exp > CMAX) ? CMAX : m_cnt + st_exp;
    chk("req_cycles", reqc, req_exp);
    chk("stall_cycles", stalls, st_exp);
    chk("stall_cnt", stall_cnt_o, m_cnt);
    chk("timeout_err", timeout_err_o, m_tmo);
    // Instruction leaves; one idle cycle with a stray ack that must be ignored.
    @(negedge clk);
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    branch_i    = 1'b0;
    zero_i      = 1'b0;
    mem_ack_i   = 1'($urandom_range(0, 1));
    mem_rdata_i = $urandom;
    #1;
    chk("idle_stall", stall_o, 0);
    chk("idle_req", mem_req_o, 0);
    chk("idle_rvld", rdata_valid_o, 0);
    chk("idle_align", align_err_o, 0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_rvld", rdata_valid_o, 0);
    chk("rst_tmo", timeout_err_o, 0);
    chk("rst_cnt", stall_cnt_o, 0);
    chk("rst_stall", stall_o, 0);
    @(negedge clk);
    rst = 1'b1;

    // Read 0x100, ack on 3rd REQ cycle -> 4 stall cycles, stall_cnt=4
    do_acc(1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 0, 0);
    chk("t1_cnt4", stall_cnt_o, 4);
    // Write 0x204 immediate ack -> 2 stall cycles
    do_acc(0, 1, 32'h204, 32'h12345678, 32'hAAAA5555, 0, 0, 0);
    // Read with no ack -> timeout after TMO REQ cycles, rdata 0
    do_acc(1, 0, 32'h3F0, 32'h0, 32'h0BADF00D, 99, 0, 0);
    chk("t3_tmo_sticky", timeout_err_o, 1);
    // Misaligned write
    do_acc(0, 1, 32'h203, 32'h11111111, 32'h0, 0, 0, 0);
    // Branch with no access, then not-taken
    @(negedge clk);
    mem_ack_i = 1'b0;
    branch_i  = 1'b1;
    zero_i    = 1'b1;
    #1;
    chk("br_pc_src", pc_src_o, 1);
    chk("br_flush", flush_o, 1);
    zero_i = 1'b0;
    #1;
    chk("br_nt_pc_src", pc_src_o, 0);
    chk("br_nt_flush", flush_o, 0);
    branch_i = 1'b0;
    // Taken branch while an access is pending: flush held until DONE
    do_acc(1, 0, 32'h40, 32'h0, 32'hCAFEF00D, 1, 1, 1);
    // Read+write together behaves as a write
    do_acc(1, 1, 32'h80, 32'h5A5A5A5A, 32'h0, 1, 0, 0);

    // Reset in the middle of REQ
    @(negedge clk);
    mem_ack_i  = 1'b0;
    mem_read_i = 1'b1;
    addr_i     = 32'h300;
    @(negedge clk);
    #1;
    chk("mid_req_up", mem_req_o, 1);
    mem_read_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_req", mem_req_o, 0);
    chk("mid_rst_cnt", stall_cnt_o, 0);
    chk("mid_rst_tmo", timeout_err_o, 0);
    chk("mid_rst_stall", stall_o, 0);
    @(negedge clk);
    rst         = 1'b1;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hFFFF0000;
    @(negedge clk);
    mem_ack_i = 1'b0;
    #1;
    chk("late_ack_rvld", rdata_valid_o, 0);
    chk("late_ack_rdata", rdata_o, 0);
    chk("late_ack_req", mem_req_o, 0);
    chk("late_ack_stall", stall_o, 0);
    m_cnt = 0;
    m_tmo = 1'b0;
    do_acc(1, 0, 32'h10, 32'h0, 32'h76543210, 0, 0, 0);

    // Randomized accesses; stall counter saturates along the way
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int          kind;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      kind = $urandom_range(0, 4);
      do_acc(kind == 1 || kind == 3, kind == 2 || kind == 3 || kind == 4, a, $urandom,
             $urandom, $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    chk("final_cnt_sat", stall_cnt_o, m_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
